// File: rtl/collision_pkg.sv
// Shared types and helpers for the N x M collision detector.
package collision_pkg;

    localparam int MAX_OBJ   = 16;
    localparam int MAX_PAIRS = 256;

    typedef enum logic {
        HIT_IMMEDIATE = 1'b0,
        HIT_DEFERRED  = 1'b1
    } hit_mode_t;

    // Row-major position of pair (i, j) in the flattened matrix.
    function automatic int pair_idx(input int i, input int j, input int nb);
        return i * nb + j;
    endfunction

endpackage

// File: rtl/hit_once_per_frame.sv
// Per-object frame hit flag plus one-cycle pulse, either on the first overlap
// of a frame or deferred to the frame boundary.
module hit_once_per_frame
    import collision_pkg::*;
(
    input  logic      clk,
    input  logic      resetN,
    input  logic      startOfFrame,
    input  logic      anyOv,
    input  hit_mode_t mode,
    output logic      pulse
);

    logic hit_q, hit_d;
    logic pulse_q, pulse_d;

    always_comb begin
        // An overlap on the boundary cycle belongs to both the closing and new frame.
        hit_d = startOfFrame ? anyOv : (hit_q | anyOv);
        if (mode == HIT_DEFERRED) begin
            pulse_d = startOfFrame & (hit_q | anyOv);
        end else begin
            pulse_d = anyOv & (startOfFrame | ~hit_q);
        end
    end

    always_ff @(posedge clk) begin
        if (resetN) begin
            hit_q   <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            hit_q   <= hit_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/collision_matrix.sv
// Generic NUM_A x NUM_B collision detector with per-object hit pulses and a
// previous-frame pair matrix. Define COLLISION_MATRIX_COUNT_EN to add hitCount.
module collision_matrix
    import collision_pkg::*;
#(
    parameter int NUM_A    = 2,
    parameter int NUM_B    = 8,
    parameter int DEFERRED = 0
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   startOfFrame,
    input  logic [NUM_A-1:0]       drawReqA,
    input  logic [NUM_B-1:0]       drawReqB,
    input  logic [NUM_A-1:0]       enA,
    input  logic [NUM_B-1:0]       enB,
    output logic [NUM_A-1:0]       hitPulseA,
    output logic [NUM_B-1:0]       hitPulseB,
    output logic [NUM_A*NUM_B-1:0] pairHit,
    output logic                   anyHit
`ifdef COLLISION_MATRIX_COUNT_EN
    ,
    output logic [7:0]             hitCount
`endif
);

    localparam int        NP   = NUM_A * NUM_B;
    localparam hit_mode_t MODE = (DEFERRED != 0) ? HIT_DEFERRED : HIT_IMMEDIATE;

    if (NUM_A < 1 || NUM_A > MAX_OBJ || NUM_B < 1 || NUM_B > MAX_OBJ) begin : g_bad_count
        $error("collision_matrix: NUM_A and NUM_B must be in 1..16");
    end
    if (NP > MAX_PAIRS) begin : g_bad_size
        $error("collision_matrix: NUM_A*NUM_B must not exceed 256");
    end

    logic [NUM_A-1:0] act_a;
    logic [NUM_B-1:0] act_b;
    logic [NUM_A-1:0] any_ov_a;
    logic [NUM_B-1:0] any_ov_b;
    logic [NP-1:0]    ov;

    assign act_a = drawReqA & enA;
    assign act_b = drawReqB & enB;

    for (genvar gi = 0; gi < NUM_A; gi++) begin : g_row
        for (genvar gj = 0; gj < NUM_B; gj++) begin : g_col
            assign ov[pair_idx(gi, gj, NUM_B)] = act_a[gi] & act_b[gj];
        end
        assign any_ov_a[gi] = act_a[gi] & (|act_b);

        hit_once_per_frame u_hit_a (
            .clk          (clk),
            .resetN       (resetN),
            .startOfFrame (startOfFrame),
            .anyOv        (any_ov_a[gi]),
            .mode         (MODE),
            .pulse        (hitPulseA[gi])
        );
    end

    for (genvar gi = 0; gi < NUM_B; gi++) begin : g_obj_b
        assign any_ov_b[gi] = act_b[gi] & (|act_a);

        hit_once_per_frame u_hit_b (
            .clk          (clk),
            .resetN       (resetN),
            .startOfFrame (startOfFrame),
            .anyOv        (any_ov_b[gi]),
            .mode         (MODE),
            .pulse        (hitPulseB[gi])
        );
    end

    logic [NP-1:0] seen_q, seen_d;
    logic [NP-1:0] pair_hit_q, pair_hit_d;
    logic          any_hit_q, any_hit_d;
    logic [NP-1:0] frame_seen;

    always_comb begin
        frame_seen = seen_q | ov;
        seen_d     = startOfFrame ? ov : frame_seen;
        pair_hit_d = startOfFrame ? frame_seen : pair_hit_q;
        any_hit_d  = |pair_hit_q;
    end

    always_ff @(posedge clk) begin
        if (resetN) begin
            seen_q     <= '0;
            pair_hit_q <= '0;
            any_hit_q  <= 1'b0;
        end else begin
            seen_q     <= seen_d;
            pair_hit_q <= pair_hit_d;
            any_hit_q  <= any_hit_d;
        end
    end

    assign pairHit = pair_hit_q;
    assign anyHit  = any_hit_q;

`ifdef COLLISION_MATRIX_COUNT_EN
    logic [7:0] hit_count_q, hit_count_d;
    logic [8:0] pair_count;

    always_comb begin
        pair_count = '0;
        for (int k = 0; k < NP; k++) begin
            pair_count = pair_count + 9'(frame_seen[k]);
        end
        hit_count_d = hit_count_q;
        if (startOfFrame) begin
            hit_count_d = (pair_count > 9'd255) ? 8'hFF : pair_count[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (resetN) begin
            hit_count_q <= '0;
        end else begin
            hit_count_q <= hit_count_d;
        end
    end

    assign hitCount = hit_count_q;
`endif

endmodule

// File: tb/tb_collision_matrix.sv
// Self-checking bench: immediate and deferred instances share stimulus; a
// reference model feeds a scoreboard and selected rows carry hand expectations.
module tb_collision_matrix;

    localparam int NA = 2;
    localparam int NB = 8;
    localparam int NP = NA * NB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, sof;
    logic [NA-1:0] req_a, en_a;
    logic [NB-1:0] req_b, en_b;

    logic [NA-1:0] pa_i, pa_d;
    logic [NB-1:0] pb_i, pb_d;
    logic [NP-1:0] pair_i, pair_d;
    logic          any_i, any_d;
`ifdef COLLISION_MATRIX_COUNT_EN
    logic [7:0]    cnt_i, cnt_d;
`endif

    collision_matrix #(.NUM_A(NA), .NUM_B(NB), .DEFERRED(0)) dut_imm (
        .clk(clk), .resetN(rst), .startOfFrame(sof),
        .drawReqA(req_a), .drawReqB(req_b), .enA(en_a), .enB(en_b),
        .hitPulseA(pa_i), .hitPulseB(pb_i), .pairHit(pair_i), .anyHit(any_i)
`ifdef COLLISION_MATRIX_COUNT_EN
        , .hitCount(cnt_i)
`endif
    );

    collision_matrix #(.NUM_A(NA), .NUM_B(NB), .DEFERRED(1)) dut_def (
        .clk(clk), .resetN(rst), .startOfFrame(sof),
        .drawReqA(req_a), .drawReqB(req_b), .enA(en_a), .enB(en_b),
        .hitPulseA(pa_d), .hitPulseB(pb_d), .pairHit(pair_d), .anyHit(any_d)
`ifdef COLLISION_MATRIX_COUNT_EN
        , .hitCount(cnt_d)
`endif
    );

    typedef struct {
        bit            rst;
        bit            sof;
        logic [NA-1:0] ra;
        logic [NB-1:0] rb;
        logic [NA-1:0] ea;
        logic [NB-1:0] eb;
        bit            chk;
        logic [NA-1:0] pa;
        logic [NB-1:0] pb;
        logic [NA-1:0] dpa;
        logic [NB-1:0] dpb;
        logic [NP-1:0] pair;
        logic          any;
        logic [7:0]    cnt;
    } vec_t;

    typedef struct {
        logic [NA-1:0] pa;
        logic [NB-1:0] pb;
        logic [NA-1:0] dpa;
        logic [NB-1:0] dpb;
        logic [NP-1:0] pair;
        logic          any;
        logic [7:0]    cnt;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    bit [NP-1:0] m_seen, m_pair;
    bit [NA-1:0] m_hita;
    bit [NB-1:0] m_hitb;
    bit [7:0]    m_cnt;

    function automatic void addv(bit r, bit s, logic [NA-1:0] ra, logic [NB-1:0] rb,
                                 logic [NB-1:0] eb);
        vec_t v;
        v = '{rst: r, sof: s, ra: ra, rb: rb, ea: '1, eb: eb, chk: 1'b0,
              pa: '0, pb: '0, dpa: '0, dpb: '0, pair: '0, any: 1'b0, cnt: '0};
        tbl.push_back(v);
    endfunction

    function automatic void addc(bit r, bit s, logic [NA-1:0] ra, logic [NB-1:0] rb,
                                 logic [NB-1:0] eb, logic [NA-1:0] pa, logic [NB-1:0] pb,
                                 logic [NA-1:0] dpa, logic [NB-1:0] dpb,
                                 logic [NP-1:0] pair, logic any, logic [7:0] cnt);
        vec_t v;
        v = '{rst: r, sof: s, ra: ra, rb: rb, ea: '1, eb: eb, chk: 1'b1,
              pa: pa, pb: pb, dpa: dpa, dpb: dpb, pair: pair, any: any, cnt: cnt};
        tbl.push_back(v);
    endfunction

    // Reference behaviour: outputs expected after the edge that samples v.
    function automatic exp_t model_step(vec_t v);
        exp_t        e;
        bit [NP-1:0] ov;
        bit [NA-1:0] rowa;
        bit [NB-1:0] colb;
        ov = '0; rowa = '0; colb = '0;
        for (int i = 0; i < NA; i++) begin
            for (int j = 0; j < NB; j++) begin
                if (v.ra[i] && v.ea[i] && v.rb[j] && v.eb[j]) begin
                    ov[i*NB+j] = 1'b1;
                    rowa[i]    = 1'b1;
                    colb[j]    = 1'b1;
                end
            end
        end
        if (v.rst) begin
            e = '{pa: '0, pb: '0, dpa: '0, dpb: '0, pair: '0, any: 1'b0, cnt: '0};
            m_seen = '0; m_pair = '0; m_hita = '0; m_hitb = '0; m_cnt = '0;
        end else begin
            e.pa  = v.sof ? rowa : (rowa & ~m_hita);
            e.pb  = v.sof ? colb : (colb & ~m_hitb);
            e.dpa = v.sof ? (m_hita | rowa) : '0;
            e.dpb = v.sof ? (m_hitb | colb) : '0;
            e.any = |m_pair;
            if (v.sof) begin
                e.pair = m_seen | ov;
                e.cnt  = 8'($countones(m_seen | ov));
                m_seen = ov;
                m_hita = rowa;
                m_hitb = colb;
            end else begin
                e.pair = m_pair;
                e.cnt  = m_cnt;
                m_seen = m_seen | ov;
                m_hita = m_hita | rowa;
                m_hitb = m_hitb | colb;
            end
            m_pair = e.pair;
            m_cnt  = e.cnt;
        end
        return e;
    endfunction

    task automatic check(input string name, input int idx, input logic [15:0] act,
                         input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        vec_t v;
        exp_t e;

        // Reset with everything requesting, then idle and open a frame.
        addc(1, 0, 2'h3, 8'hFF, 8'hFF, 0, 0, 0, 0, 0, 0, 0);
        addc(1, 0, 2'h3, 8'hFF, 8'hFF, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) addv(0, 0, 0, 0, 8'hFF);
        addv(0, 1, 0, 0, 8'hFF);
        // Immediate single hit A0 x B3 held 5 cycles.
        addc(0, 0, 2'h1, 8'h08, 8'hFF, 2'h1, 8'h08, 0, 0, 16'h0000, 0, 0);
        addc(0, 0, 2'h1, 8'h08, 8'hFF, 0, 0, 0, 0, 16'h0000, 0, 0);
        for (int k = 0; k < 3; k++) addv(0, 0, 2'h1, 8'h08, 8'hFF);
        addv(0, 0, 0, 0, 8'hFF);
        addv(0, 0, 0, 0, 8'hFF);
        addc(0, 1, 0, 0, 8'hFF, 0, 0, 2'h1, 8'h08, 16'h0008, 0, 1);
        addc(0, 0, 0, 0, 8'hFF, 0, 0, 0, 0, 16'h0008, 1, 1);
        // Same overlap in the next frame pulses again.
        addc(0, 0, 2'h1, 8'h08, 8'hFF, 2'h1, 8'h08, 0, 0, 16'h0008, 1, 1);
        addv(0, 0, 2'h1, 8'h08, 8'hFF);
        addv(0, 0, 2'h1, 8'h08, 8'hFF);
        addv(0, 0, 0, 0, 8'hFF);
        addc(0, 1, 0, 0, 8'hFF, 0, 0, 2'h1, 8'h08, 16'h0008, 1, 1);
        // B3 masked off: no hits this frame.
        addc(0, 0, 2'h1, 8'h08, 8'hF7, 0, 0, 0, 0, 16'h0008, 1, 1);
        addv(0, 0, 2'h1, 8'h08, 8'hF7);
        addv(0, 0, 2'h1, 8'h08, 8'hF7);
        addv(0, 0, 0, 0, 8'hFF);
        addc(0, 1, 0, 0, 8'hFF, 0, 0, 0, 0, 16'h0000, 1, 0);
        addc(0, 0, 0, 0, 8'hFF, 0, 0, 0, 0, 16'h0000, 0, 0);
        // A1 x B0 then A1 x B7.
        addc(0, 0, 2'h2, 8'h01, 8'hFF, 2'h2, 8'h01, 0, 0, 16'h0000, 0, 0);
        addv(0, 0, 2'h2, 8'h01, 8'hFF);
        addc(0, 0, 2'h2, 8'h80, 8'hFF, 0, 8'h80, 0, 0, 16'h0000, 0, 0);
        addc(0, 0, 2'h2, 8'h80, 8'hFF, 0, 0, 0, 0, 16'h0000, 0, 0);
        addv(0, 0, 0, 0, 8'hFF);
        addc(0, 1, 0, 0, 8'hFF, 0, 0, 2'h2, 8'h81, 16'h8100, 0, 2);
        addc(0, 0, 0, 0, 8'hFF, 0, 0, 0, 0, 16'h8100, 1, 2);
        // Overlap coinciding with startOfFrame counts for both frames.
        addc(0, 1, 2'h1, 8'h01, 8'hFF, 2'h1, 8'h01, 2'h1, 8'h01, 16'h0001, 1, 1);
        addv(0, 0, 0, 0, 8'hFF);
        addc(0, 1, 0, 0, 8'hFF, 0, 0, 2'h1, 8'h01, 16'h0001, 1, 1);
        // Mid-frame reset discards the partial frame.
        addv(0, 0, 2'h3, 8'hFF, 8'hFF);
        addc(1, 0, 2'h3, 8'hFF, 8'hFF, 0, 0, 0, 0, 16'h0000, 0, 0);
        addv(0, 0, 0, 0, 8'hFF);
        addc(0, 1, 0, 0, 8'hFF, 0, 0, 0, 0, 16'h0000, 0, 0);
        // Random traffic, checked against the model only.
        for (int k = 0; k < 60; k++) begin
            vec_t r;
            r = '{rst: ($urandom_range(0, 49) == 0), sof: ($urandom_range(0, 5) == 0),
                  ra: NA'($urandom), rb: NB'($urandom),
                  ea: ($urandom_range(0, 3) == 0) ? NA'($urandom) : '1,
                  eb: ($urandom_range(0, 3) == 0) ? NB'($urandom) : '1,
                  chk: 1'b0, pa: '0, pb: '0, dpa: '0, dpb: '0, pair: '0, any: 1'b0, cnt: '0};
            tbl.push_back(r);
        end

        for (int k = 0; k < tbl.size(); k++) begin
            v     = tbl[k];
            rst   = v.rst;
            sof   = v.sof;
            req_a = v.ra;
            req_b = v.rb;
            en_a  = v.ea;
            en_b  = v.eb;
            sb.push_back(model_step(v));
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check("imm_pulse_a", k, 16'(pa_i), 16'(e.pa));
            check("imm_pulse_b", k, 16'(pb_i), 16'(e.pb));
            check("def_pulse_a", k, 16'(pa_d), 16'(e.dpa));
            check("def_pulse_b", k, 16'(pb_d), 16'(e.dpb));
            check("imm_pair",    k, 16'(pair_i), 16'(e.pair));
            check("def_pair",    k, 16'(pair_d), 16'(e.pair));
            check("imm_any",     k, 16'(any_i), 16'(e.any));
            check("def_any",     k, 16'(any_d), 16'(e.any));
`ifdef COLLISION_MATRIX_COUNT_EN
            check("imm_count",   k, 16'(cnt_i), 16'(e.cnt));
            check("def_count",   k, 16'(cnt_d), 16'(e.cnt));
`endif
            if (v.chk) begin
                check("hand_imm_pulse_a", k, 16'(pa_i), 16'(v.pa));
                check("hand_imm_pulse_b", k, 16'(pb_i), 16'(v.pb));
                check("hand_def_pulse_a", k, 16'(pa_d), 16'(v.dpa));
                check("hand_def_pulse_b", k, 16'(pb_d), 16'(v.dpb));
                check("hand_pair",        k, 16'(pair_i), 16'(v.pair));
                check("hand_any",         k, 16'(any_d), 16'(v.any));
`ifdef COLLISION_MATRIX_COUNT_EN
                check("hand_count",       k, 16'(cnt_d), 16'(v.cnt));
`endif
            end
            $display("[TB] vec %0d rst=%b sof=%b reqA=%h reqB=%h enB=%h -> pA=%h pB=%h dA=%h dB=%h pair=%h any=%b",
                     k, v.rst, v.sof, v.ra, v.rb, v.eb, pa_i, pb_i, pa_d, pb_d, pair_i, any_i);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
